// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS        = 8;
    localparam logic        UART_IDLE_LEVEL       = 1'b1;
    localparam int unsigned UART_BAUD_DIV_DEFAULT = 434;  // 50 MHz / 115200

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Width of a counter that has to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period timer for the UART transmitter: bit_tick on the last cycle of each bit.
module uart_tx_baud
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned      CNT_W   = cnt_width(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign bit_tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_control.sv
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits, no parity.
module uart_tx_control
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_pin_out,
    output logic       tx_busy,
    output logic       tx_done_sig
);

    localparam int unsigned IDX_W = cnt_width(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t                  state;
    logic [UART_DATA_BITS-1:0]  shreg;
    logic [IDX_W-1:0]           bit_idx;
    logic                       stop_idx;
    logic                       pin_q;
    logic                       ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       accept;
    logic                       bit_tick;

    assign accept = tx_valid && ready_q;

    uart_tx_baud #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (state != IDLE),
        .bit_tick(bit_tick)
    );

    // All outputs come straight from flops so the serial line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            pin_q    <= UART_IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= tx_data;
                        pin_q   <= ~UART_IDLE_LEVEL;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        pin_q   <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            pin_q    <= UART_IDLE_LEVEL;
                            stop_idx <= 1'b0;
                            state    <= STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            pin_q   <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (stop_idx == STOP_LAST) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_pin_out  = pin_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done_sig = done_q;

endmodule
